// File: rtl/servo_arbiter_if.sv
// Purpose : servo control-word bus between three requesters, the arbiter and servo_controller.
// Latency : none (wires only).
// Backpressure : stb/ack; a sender holds stb and data until the edge where stb and ack are both high.
// Signals:
//   input_{a,b,c} / input_{a,b,c}_stb / input_{a,b,c}_ack  - requester words and handshake
//   output_control / output_control_stb / output_control_ack - merged stream to servo_controller
//   output_grant   - source of the held word (0=A, 1=B, 2=C)
//   output_timeout - one-cycle pulse when a held word is dropped by the watchdog
// Modports: slave = arbiter view, master = requesters + controller view.
interface servo_arbiter_if;
  logic [15:0] input_a;
  logic [15:0] input_b;
  logic [15:0] input_c;
  logic        input_a_stb;
  logic        input_b_stb;
  logic        input_c_stb;
  logic        input_a_ack;
  logic        input_b_ack;
  logic        input_c_ack;
  logic [15:0] output_control;
  logic        output_control_stb;
  logic        output_control_ack;
  logic [1:0]  output_grant;
  logic        output_timeout;

  modport slave (
    input  input_a, input_b, input_c,
    input  input_a_stb, input_b_stb, input_c_stb,
    output input_a_ack, input_b_ack, input_c_ack,
    output output_control, output_control_stb,
    input  output_control_ack,
    output output_grant, output_timeout
  );

  modport master (
    output input_a, input_b, input_c,
    output input_a_stb, input_b_stb, input_c_stb,
    input  input_a_ack, input_b_ack, input_c_ack,
    input  output_control, output_control_stb,
    output output_control_ack,
    input  output_grant, output_timeout
  );
endinterface

// File: rtl/servo_arbiter.sv
// Purpose : three-way round-robin merge of 16-bit servo control words into one stb/ack stream.
// Latency : input stb sampled in IDLE -> input ack next cycle -> output stb the cycle after; 3 clocks/word minimum.
// Backpressure : the held word waits in SEND until output_control_ack (or the watchdog drops it); unserved requesters keep stb high.
// Ports:
//   clk - single clock, rising edge
//   rst - synchronous active-low reset
//   bus - servo_arbiter_if.slave (requester words/handshakes, output stream, grant, timeout)
// Parameter TIMEOUT (1..65535): SEND cycles without ack before the word is dropped.
// Optional feature: define SERVO_ARB_WATCHDOG_EN to build the watchdog; otherwise
// output_timeout is tied 0 and SEND waits indefinitely.
module servo_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  servo_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  last;
  logic [1:0]  win;
  logic        win_vld;
  logic [2:0]  req;

  logic [2:0]  ack_r;
  logic [15:0] ctrl_r;
  logic        ctrl_stb_r;
  logic [1:0]  grant_r;
  logic [15:0] sel_word;
  logic        wd_expire;

  assign req = {bus.input_c_stb, bus.input_b_stb, bus.input_a_stb};

  // Search begins one past the last granted source and wraps, so an idle
  // source costs nothing: the first requester in that order wins directly.
  always_comb begin
    win     = 2'd0;
    win_vld = |req;
    case (last)
      2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    case (grant_r)
      2'd0:    sel_word = bus.input_a;
      2'd1:    sel_word = bus.input_b;
      default: sel_word = bus.input_c;
    endcase
  end

`ifdef SERVO_ARB_WATCHDOG_EN
  // The counter holds the number of unacked SEND cycles already spent; the
  // word is dropped on the edge that would take it to TIMEOUT, so stb is
  // high for exactly TIMEOUT cycles.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;
  logic        timeout_r;

  assign wd_expire = (state == SEND) && !bus.output_control_ack && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt    <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= wd_expire;
      if (state == ACCEPT) begin
        wd_cnt <= 16'd0;
      end else if ((state == SEND) && !bus.output_control_ack) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  assign bus.output_timeout = timeout_r;
`else
  logic unused_timeout;

  assign unused_timeout     = ^16'(TIMEOUT);
  assign wd_expire          = 1'b0;
  assign bus.output_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. Arbitration only happens in IDLE; late requests wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCEPT;
      ACCEPT:  state_nxt = SEND;
      SEND:    if (bus.output_control_ack || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs. The input ack is set on the IDLE->ACCEPT edge so it
  // is high during ACCEPT only; the word is captured on the edge that
  // completes that input transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last       <= 2'd2;
      ack_r      <= 3'b000;
      ctrl_r     <= 16'd0;
      ctrl_stb_r <= 1'b0;
      grant_r    <= 2'd0;
    end else begin
      ack_r <= 3'b000;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_r <= win;
            ack_r   <= 3'b001 << win;
          end
        end
        ACCEPT: begin
          ctrl_r     <= sel_word;
          ctrl_stb_r <= 1'b1;
          last       <= grant_r;
        end
        SEND: begin
          if (bus.output_control_ack || wd_expire) begin
            ctrl_stb_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.input_a_ack        = ack_r[0];
  assign bus.input_b_ack        = ack_r[1];
  assign bus.input_c_ack        = ack_r[2];
  assign bus.output_control     = ctrl_r;
  assign bus.output_control_stb = ctrl_stb_r;
  assign bus.output_grant       = grant_r;

endmodule

// File: tb/tb_servo_arbiter.sv
// Purpose : directed self-checking bench for servo_arbiter.
// Latency : n/a.
// Backpressure : requesters drop stb after their transfer unless told to keep requesting.
module tb_servo_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  servo_arbiter_if bus();

  servo_arbiter #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SERVO_ARB_WATCHDOG_EN
  localparam int BP = 6;
`else
  localparam int BP = 20;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int          cycle       = 0;
  int          in_cnt[3];
  int          ack_hi      = 0;
  int          to_hi       = 0;
  logic [2:0]  keep;
  logic [17:0] out_q[$];
  int          out_cyc[$];
  logic [15:0] fw[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock. Transfers are judged from the values just before the edge;
  // outputs are sampled 1 time unit after it.
  task automatic step();
    logic [2:0]  ix;
    logic        ox;
    logic [17:0] ow;
    ix = {bus.input_c_stb & bus.input_c_ack,
          bus.input_b_stb & bus.input_b_ack,
          bus.input_a_stb & bus.input_a_ack};
    ox = bus.output_control_stb & bus.output_control_ack;
    ow = {bus.output_grant, bus.output_control};
    @(posedge clk);
    #1;
    cycle++;
    if (ix[0] === 1'b1) begin in_cnt[0]++; if (!keep[0]) bus.input_a_stb = 1'b0; end
    if (ix[1] === 1'b1) begin in_cnt[1]++; if (!keep[1]) bus.input_b_stb = 1'b0; end
    if (ix[2] === 1'b1) begin in_cnt[2]++; if (!keep[2]) bus.input_c_stb = 1'b0; end
    if (ox === 1'b1) begin
      out_q.push_back(ow);
      out_cyc.push_back(cycle);
    end
    if (bus.input_a_ack === 1'b1) ack_hi++;
    if (bus.input_b_ack === 1'b1) ack_hi++;
    if (bus.input_c_ack === 1'b1) ack_hi++;
    if (bus.output_timeout === 1'b1) to_hi++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  initial begin
    int n0;
    int hi;
    int stable;
    rst                    = 1'b0;
    bus.input_a            = 16'd0;
    bus.input_b            = 16'd0;
    bus.input_c            = 16'd0;
    bus.input_a_stb        = 1'b0;
    bus.input_b_stb        = 1'b0;
    bus.input_c_stb        = 1'b0;
    bus.output_control_ack = 1'b0;
    keep                   = 3'b000;
    for (int i = 0; i < 3; i++) in_cnt[i] = 0;
    fw[0] = 16'hA000;
    fw[1] = 16'hB000;
    fw[2] = 16'hC000;

    // Reset state
    do_reset(2);
    check("rst_acks", {bus.input_c_ack, bus.input_b_ack, bus.input_a_ack}, 3'b000);
    check("rst_stb", bus.output_control_stb, 1'b0);
    check("rst_grant", bus.output_grant, 2'd0);
    check("rst_ctrl", bus.output_control, 16'd0);
    check("rst_timeout", bus.output_timeout, 1'b0);
    to_hi = 0;

    // Single request from A, output ack held high
    bus.input_a            = 16'h0312;
    bus.input_a_stb        = 1'b1;
    bus.output_control_ack = 1'b1;
    step();
    check("t1_ack_a", bus.input_a_ack, 1'b1);
    check("t1_ack_bc", {bus.input_c_ack, bus.input_b_ack}, 2'b00);
    check("t1_grant", bus.output_grant, 2'd0);
    check("t1_stb_early", bus.output_control_stb, 1'b0);
    step();
    check("t1_ack_a_once", bus.input_a_ack, 1'b0);
    check("t1_stb", bus.output_control_stb, 1'b1);
    check("t1_ctrl", bus.output_control, 16'h0312);
    step();
    check("t1_stb_clear", bus.output_control_stb, 1'b0);
    check("t1_nout", out_q.size(), 1);
    check("t1_word", out_q[0], {2'd0, 16'h0312});
    check("t1_nin_a", in_cnt[0], 1);

    // Fairness: all three requesting continuously
    do_reset(2);
    out_q.delete();
    out_cyc.delete();
    keep            = 3'b111;
    bus.input_a     = fw[0];
    bus.input_b     = fw[1];
    bus.input_c     = fw[2];
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    bus.input_c_stb = 1'b1;
    repeat (18) step();
    keep = 3'b000;
    repeat (12) step();
    check("t2_nout", out_q.size(), 9);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_word%0d", i), out_q[i], {2'(i % 3), fw[i % 3]});
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_period%0d", i), out_cyc[i + 1] - out_cyc[i], 3);
    end

    // Backpressure: B holds a word while the controller stalls
    out_q.delete();
    bus.input_b            = 16'h0180;
    bus.input_b_stb        = 1'b1;
    bus.output_control_ack = 1'b0;
    step();
    check("t3_grant", bus.output_grant, 2'd1);
    check("t3_ack_b", bus.input_b_ack, 1'b1);
    step();
    ack_hi = 0;
    stable = 0;
    for (int k = 0; k < BP; k++) begin
      if (bus.output_control_stb === 1'b1 && bus.output_control === 16'h0180) stable++;
      if (k < BP - 1) step();
    end
    check("t3_nout_stall", out_q.size(), 0);
    bus.output_control_ack = 1'b1;
    step();
    check("t3_stable", stable, BP);
    check("t3_no_acks", ack_hi, 0);
    check("t3_nout", out_q.size(), 1);
    check("t3_word", out_q[0], {2'd1, 16'h0180});
    check("t3_stb_clear", bus.output_control_stb, 1'b0);

    // Skip: A transfers, then only C requests
    out_q.delete();
    bus.input_a     = 16'h0011;
    bus.input_a_stb = 1'b1;
    repeat (4) step();
    bus.input_c     = 16'h0C0C;
    bus.input_c_stb = 1'b1;
    step();
    check("t4_grant", bus.output_grant, 2'd2);
    check("t4_ack_c", bus.input_c_ack, 1'b1);
    check("t4_ack_ab", {bus.input_b_ack, bus.input_a_ack}, 2'b00);
    repeat (3) step();
    check("t4_nout", out_q.size(), 2);
    check("t4_word", out_q[1], {2'd2, 16'h0C0C});

    // Reset while holding a word in SEND
    out_q.delete();
    keep                   = 3'b001;
    bus.input_a            = 16'h0555;
    bus.input_a_stb        = 1'b1;
    bus.output_control_ack = 1'b0;
    step();
    step();
    check("t5_held", {bus.output_control_stb, bus.output_control}, {1'b1, 16'h0555});
    n0  = in_cnt[0];
    rst = 1'b0;
    step();
    check("t5_rst_stb", bus.output_control_stb, 1'b0);
    check("t5_rst_acks", {bus.input_c_ack, bus.input_b_ack, bus.input_a_ack}, 3'b000);
    check("t5_rst_ctrl", bus.output_control, 16'd0);
    check("t5_rst_grant", bus.output_grant, 2'd0);
    rst                    = 1'b1;
    keep                   = 3'b000;
    bus.output_control_ack = 1'b1;
    repeat (8) step();
    check("t5_nout", out_q.size(), 1);
    check("t5_word", out_q[0], {2'd0, 16'h0555});
    check("t5_reack", in_cnt[0] - n0, 1);

    // Watchdog / indefinite wait
    out_q.delete();
    bus.input_c            = 16'h0ABC;
    bus.input_c_stb        = 1'b1;
    bus.output_control_ack = 1'b0;
`ifdef SERVO_ARB_WATCHDOG_EN
    to_hi = 0;
    step();
    step();
    hi = (bus.output_control_stb === 1'b1) ? 1 : 0;
    repeat (20) begin
      step();
      if (bus.output_control_stb === 1'b1) hi++;
    end
    check("t6_stb_cycles", hi, 8);
    check("t6_pulses", to_hi, 1);
    check("t6_dropped", out_q.size(), 0);
    bus.input_a            = 16'h0123;
    bus.input_a_stb        = 1'b1;
    bus.output_control_ack = 1'b1;
    repeat (6) step();
    check("t6_nout", out_q.size(), 1);
    check("t6_word", out_q[0], {2'd0, 16'h0123});
`else
    step();
    step();
    hi = (bus.output_control_stb === 1'b1) ? 1 : 0;
    repeat (40) begin
      step();
      if (bus.output_control_stb === 1'b1) hi++;
    end
    check("t6_stb_cycles", hi, 41);
    check("t6_no_timeout", to_hi, 0);
    bus.output_control_ack = 1'b1;
    step();
    check("t6_nout", out_q.size(), 1);
    check("t6_word", out_q[0], {2'd2, 16'h0ABC});
    check("t6_stb_clear", bus.output_control_stb, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
